// File: rtl/run_det_pkg.sv
// rtl/run_det_pkg.sv - shared state and mode encodings for the run-length detector
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    MATCH = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_ONE  = 2'b01;
  // Any mode with bit 1 set matches runs of either value; 2'b10 is the canonical form.
  localparam logic [1:0] MODE_ANY  = 2'b10;

  function automatic logic qualify(input logic [1:0] mode, input logic v);
    return mode[1] | ((mode == MODE_ZERO) & ~v) | ((mode == MODE_ONE) & v);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and load-to-1
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(1);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/run_detector.sv
// rtl/run_detector.sv - Moore run-length detector on a qualified serial bit stream
module run_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int EVT_W   = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             w_valid,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             q,
  output logic             q_val,
  output logic [CNT_W-1:0] run_len,
  output logic             evt_pulse,
  output logic [EVT_W-1:0] evt_cnt
);

  state_t           state, state_nxt;
  logic             accept;
  logic             new_run;
  logic             enter;
  logic [CNT_W-1:0] len_nxt;

  assign accept  = w_valid & ~clr;
  assign new_run = (state == IDLE) | (w != q_val);

  // Decide on the run length this sample produces, before the counter updates.
  always_comb begin
    state_nxt = state;
    len_nxt   = run_len;
    enter     = 1'b0;
    if (accept) begin
      if (new_run) begin
        len_nxt = CNT_W'(1);
      end else if (run_len != '1) begin
        len_nxt = run_len + 1'b1;
      end
      if ((len_nxt >= CNT_W'(RUN_LEN)) && qualify(mode, w)) begin
        state_nxt = MATCH;
      end else begin
        state_nxt = RUN;
      end
      enter = (state_nxt == MATCH) && (state != MATCH);
    end
    if (clr) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      q_val     <= 1'b0;
      evt_pulse <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      q_val     <= 1'b0;
      evt_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      evt_pulse <= enter;
      if (accept) begin
        q_val <= w;
      end
    end
  end

  assign q = (state == MATCH);

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .Reset (Reset),
    .clr   (clr),
    .load  (accept & new_run),
    .inc   (accept & ~new_run),
    .cnt   (run_len)
  );

  sat_counter #(.W(EVT_W)) u_evt_cnt (
    .clk   (clk),
    .Reset (Reset),
    .clr   (clr),
    .load  (1'b0),
    .inc   (enter),
    .cnt   (evt_cnt)
  );

endmodule

// File: tb/tb_run_detector.sv
// tb/tb_run_detector.sv - randomized bench for run_detector against a history-based model
module tb_run_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset, w_valid, w, clr;
  logic [1:0] mode;

  logic q_a, qv_a, ep_a; logic [7:0] rl_a; logic [15:0] ec_a;
  logic q_b, qv_b, ep_b; logic [2:0] rl_b; logic [1:0]  ec_b;
  logic q_c, qv_c, ep_c; logic [3:0] rl_c; logic [3:0]  ec_c;

  run_detector #(.RUN_LEN(4), .CNT_W(8), .EVT_W(16)) dut_a (
    .clk(clk), .Reset(Reset), .w_valid(w_valid), .w(w), .mode(mode), .clr(clr),
    .q(q_a), .q_val(qv_a), .run_len(rl_a), .evt_pulse(ep_a), .evt_cnt(ec_a));
  run_detector #(.RUN_LEN(2), .CNT_W(3), .EVT_W(2)) dut_b (
    .clk(clk), .Reset(Reset), .w_valid(w_valid), .w(w), .mode(mode), .clr(clr),
    .q(q_b), .q_val(qv_b), .run_len(rl_b), .evt_pulse(ep_b), .evt_cnt(ec_b));
  run_detector #(.RUN_LEN(1), .CNT_W(4), .EVT_W(4)) dut_c (
    .clk(clk), .Reset(Reset), .w_valid(w_valid), .w(w), .mode(mode), .clr(clr),
    .q(q_c), .q_val(qv_c), .run_len(rl_c), .evt_pulse(ep_c), .evt_cnt(ec_c));

  int rl_p[3]   = '{4, 2, 1};
  int cmax_p[3] = '{255, 7, 15};
  int emax_p[3] = '{65535, 3, 15};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_tests++;
    if (obs !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: the accepted samples since reset/clr, plus per-instance match history.
  bit hist[$];
  bit m_q[3];
  bit m_p[3];
  int m_e[3];

  function automatic int trail();
    int n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  function automatic bit qual(input logic [1:0] md, input bit v);
    if (md >= 2) return 1'b1;
    return (md == 0) ? !v : v;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int k = 0; k < 3; k++) begin
      m_q[k] = 0; m_p[k] = 0; m_e[k] = 0;
    end
  endtask

  task automatic model_step(input bit v, input bit b, input logic [1:0] md, input bit c);
    int run;
    bit qn;
    if (c) begin
      model_clear();
    end else if (v) begin
      hist.push_back(b);
      run = trail();
      for (int k = 0; k < 3; k++) begin
        qn = (min2(run, cmax_p[k]) >= rl_p[k]) && qual(md, b);
        m_p[k] = qn && !m_q[k];
        if (m_p[k] && m_e[k] < emax_p[k]) m_e[k]++;
        m_q[k] = qn;
      end
    end else begin
      for (int k = 0; k < 3; k++) m_p[k] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] o_q, o_qv, o_rl, o_ep, o_ec;
    int exp_qv;
    exp_qv = (hist.size() == 0) ? 0 : int'(hist[hist.size()-1]);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin o_q = 32'(q_a); o_qv = 32'(qv_a); o_rl = 32'(rl_a); o_ep = 32'(ep_a); o_ec = 32'(ec_a); end
        1: begin o_q = 32'(q_b); o_qv = 32'(qv_b); o_rl = 32'(rl_b); o_ep = 32'(ep_b); o_ec = 32'(ec_b); end
        default: begin o_q = 32'(q_c); o_qv = 32'(qv_c); o_rl = 32'(rl_c); o_ep = 32'(ep_c); o_ec = 32'(ec_c); end
      endcase
      check($sformatf("%s/%0d q", tag, k), o_q, int'(m_q[k]));
      check($sformatf("%s/%0d q_val", tag, k), o_qv, exp_qv);
      check($sformatf("%s/%0d run_len", tag, k), o_rl, min2(trail(), cmax_p[k]));
      check($sformatf("%s/%0d evt_pulse", tag, k), o_ep, int'(m_p[k]));
      check($sformatf("%s/%0d evt_cnt", tag, k), o_ec, m_e[k]);
    end
  endtask

  task automatic cyc(input bit v, input bit b, input logic [1:0] md, input bit c, input string tag);
    w_valid = v; w = b; mode = md; clr = c;
    @(posedge clk);
    model_step(v, b, md, c);
    #1;
    check_all(tag);
  endtask

  // Called just after a checked edge: pulls Reset low between edges and checks without a clock edge.
  task automatic async_reset(input string tag);
    #2 Reset = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    #2 Reset = 1'b1;
  endtask

  initial begin
    bit lastw;
    logic [1:0] md;
    Reset = 1'b0; w_valid = 1'b0; w = 1'b0; mode = 2'b00; clr = 1'b0;
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk) Reset = 1'b1;
    cyc(0, 0, 2'b00, 0, "post_reset");

    for (int i = 0; i < 4; i++) cyc(1, 0, 2'b00, 0, "zeros");
    check("zeros_q", 32'(q_a), 1);
    check("zeros_pulse", 32'(ep_a), 1);
    check("zeros_evt", 32'(ec_a), 1);
    cyc(1, 0, 2'b00, 0, "fifth_zero");
    check("fifth_rl", 32'(rl_a), 5);
    check("fifth_pulse", 32'(ep_a), 0);
    async_reset("rst_mid_match");
    check("rst_mid_q", 32'(q_a), 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 2'b00, 0, "gap_smp");
      cyc(0, 1'($urandom), 2'b00, 0, "gap_idle");
      cyc(0, 1'($urandom), 2'b00, 0, "gap_idle");
    end
    check("gap_q", 32'(q_a), 1);
    cyc(1, 1, 2'b00, 0, "gap_break");
    check("break_q", 32'(q_a), 0);
    check("break_qv", 32'(qv_a), 1);
    check("break_rl", 32'(rl_a), 1);

    cyc(0, 0, 2'b00, 1, "clr");
    for (int i = 0; i < 4; i++) cyc(1, 0, 2'b01, 0, "mode01");
    check("mode01_q", 32'(q_a), 0);
    check("mode01_rl", 32'(rl_a), 4);
    cyc(1, 0, 2'b10, 0, "mode10");
    check("mode10_q", 32'(q_a), 1);
    check("mode10_evt", 32'(ec_a), 1);

    cyc(0, 0, 2'b10, 1, "clr");
    for (int i = 0; i < 10; i++) cyc(1, 1, 2'b10, 0, "sat_run");
    check("sat_rl_b", 32'(rl_b), 7);
    cyc(0, 0, 2'b10, 1, "clr");
    for (int i = 0; i < 10; i++) cyc(1, 1'((i / 2) % 2), 2'b10, 0, "evt_sat");
    check("evt_sat_b", 32'(ec_b), 3);

    cyc(0, 0, 2'b00, 1, "clr");
    for (int i = 0; i < 4; i++) cyc(1, 0, 2'b00, 0, "pre_clr");
    cyc(1, 1, 2'b00, 1, "clr_valid");
    check("clrv_q", 32'(q_a), 0);
    check("clrv_rl", 32'(rl_a), 0);
    check("clrv_evt", 32'(ec_a), 0);
    cyc(1, 1, 2'b01, 0, "after_clr");
    check("after_clr_rl", 32'(rl_a), 1);
    check("after_clr_qv", 32'(qv_a), 1);

    cyc(0, 0, 2'b00, 1, "clr");
    cyc(1, 0, 2'b00, 0, "rl1_first");
    check("rl1_q", 32'(q_c), 1);
    check("rl1_pulse", 32'(ep_c), 1);

    lastw = 1'b0;
    md = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      bit v, b, c;
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      v = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 9) < 8) ? lastw : ~lastw;
      lastw = b;
      if ($urandom_range(0, 39) == 0) md = 2'($urandom);
      c = ($urandom_range(0, 99) == 0);
      cyc(v, b, md, c, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
